decrypt_word_packer: RTL and testbench
======================================

Name: decrypt_word_packer

Overview:
- Sits directly downstream of the decrypt pipeline and consumes its byte stream (v, dout).
- Packs decrypted bytes into 32-bit words and buffers them in a small FIFO.
- Presents the words on a valid/ready interface to the system bus side.
- The decrypt pipe has no backpressure, so this block absorbs bursts and flags any loss through a sticky overflow bit.

Parameters:
DEPTH, 4, number of 32-bit FIFO entries; power of two, at least 2
BIG_ENDIAN, 0, 0: first byte of a word goes to bits 7:0; 1: first byte goes to bits 31:24

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
v  in  1  decrypted byte valid (from decrypt pipe v)
din  in  8  decrypted byte (from decrypt pipe dout)
flush  in  1  single-cycle request to emit the partial word
out_valid  out  1  FIFO head word available
out_ready  in  1  downstream accepts the head word
out_data  out  32  head word; unused lanes are zero
out_bytes  out  3  number of valid bytes in out_data, 1..4
overflow  out  1  sticky: a word was dropped
clr_ovf  in  1  clears overflow
fill_level  out  $clog2(DEPTH)+1  FIFO occupancy
byte_cnt  out  16  total bytes accepted (optional feature)

Behaviour:
- Reset (async, rst=1): pack_cnt=0, pack register=0, FIFO empty.
  - Outputs: out_valid=0, out_data=0, out_bytes=0, overflow=0, fill_level=0, byte_cnt=0.
- Pack state machine is held in pack_cnt:
  - EMPTY: pack_cnt=0.
  - PARTIAL: pack_cnt=1..3.
- Byte placement:
  - v=1 writes din into lane pack_cnt; lane k is bits 8k+7:8k, or bits 31-8k:24-8k when BIG_ENDIAN=1.
  - pack_cnt then increments.
- Full word:
  - When v=1 with pack_cnt=3, the completed word (including din) is pushed on that same edge with out_bytes=4.
  - pack_cnt returns to 0.
- Flush:
  - Effective count = pack_cnt + v.
  - If effective count is 1..3, the partial word is pushed with out_bytes equal to that count; unused lanes are zero; pack_cnt goes to 0.
  - If effective count is 0, flush is a no-op.
  - If effective count is 4, there is exactly one push of the full word (no extra empty push).
- Latency: a word pushed on edge N is visible with out_valid=1 from cycle N+1 if the FIFO was empty. Otherwise it appears behind older entries in order.
- Pop: on an edge where out_valid and out_ready are both 1.
  - out_data and out_bytes present the head entry.
  - When the FIFO is empty, out_data=0 and out_bytes=0.
- Simultaneous push and pop:
  - Always legal when the FIFO is not empty; fill_level is unchanged.
  - With the FIFO full, a push coincident with a pop is accepted.
- Full FIFO with a push and no pop:
  - The word is dropped and overflow is set.
  - Pack state still clears to EMPTY.
  - FIFO contents are untouched.
- overflow:
  - Cleared by clr_ovf.
  - If set and clear happen in the same cycle, set wins.
- Pointers wrap modulo DEPTH; fill_level ranges 0..DEPTH.
- out_valid is registered, derived from fill_level != 0. No combinational path from out_ready to out_valid.
- Reset asserted mid-word or mid-burst discards the partial word and all FIFO contents immediately.

Optional Feature:
Macro: DECRYPT_PACK_BYTE_CNT_EN.
- Defined:
  - byte_cnt increments by 1 on every cycle with v=1, wrapping 16'hFFFF to 0.
  - Dropped words still count their bytes.
  - byte_cnt resets to 0.
- Not defined:
  - The counter logic is absent and byte_cnt is tied to 0.
  - The port list is unchanged.

Test Plan:
- BIG_ENDIAN=0, out_ready=1, v on 4 consecutive cycles with din=8'h11,22,33,44 -> out_valid for one cycle, 2 cycles after the first byte's successor edge, with out_data=32'h44332211 and out_bytes=4. With BIG_ENDIAN=1 -> out_data=32'h11223344.
- Bytes 8'hAA, 8'hBB, then flush alone -> out_data=32'h0000BBAA, out_bytes=2. A further flush with no bytes pending -> no push, fill_level stays 0.
- Pack_cnt=3, then v=1 with din=8'hDD and flush=1 in the same cycle -> exactly one word with out_bytes=4; fill_level=1.
- DEPTH=4, out_ready=0, 20 bytes streamed -> 4 words stored with fill_level=4 and a fifth word dropped, so overflow=1. Then out_ready=1 -> the first 4 words drain in order. Then clr_ovf -> overflow=0. Clear and a new drop in the same cycle -> overflow stays 1.
- FIFO full and out_ready=1 while a fourth byte arrives -> no overflow, fill_level stays 4, order preserved.
- rst pulse asynchronous to clk while pack_cnt=2 and fill_level=3 -> all outputs 0 immediately. The next 4 bytes form a clean word with no stale lanes. With the macro defined, byte_cnt counts from 0.

Source files
------------

// File: rtl/decrypt_word_packer_if.sv
// decrypt_word_packer_if
// Byte-in / word-out bundle between the decrypt pipe, the packer and the
// system-bus consumer. DEPTH must match the packer instance so that
// fill_level has the right width.
interface decrypt_word_packer_if #(
    parameter int DEPTH = 4
);
    localparam int FW = $clog2(DEPTH) + 1;

    // Byte stream from the decrypt pipe (no backpressure)
    logic          v;
    logic [7:0]    din;
    logic          flush;

    // Word stream towards the bus side
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [2:0]    out_bytes;

    // Status / control
    logic          overflow;
    logic          clr_ovf;
    logic [FW-1:0] fill_level;
    logic [15:0]   byte_cnt;

    // Packer side
    modport slave (
        input  v, din, flush, out_ready, clr_ovf,
        output out_valid, out_data, out_bytes, overflow, fill_level, byte_cnt
    );

    // Stimulus / system side
    modport master (
        output v, din, flush, out_ready, clr_ovf,
        input  out_valid, out_data, out_bytes, overflow, fill_level, byte_cnt
    );
endinterface

// File: rtl/decrypt_word_packer.sv
// decrypt_word_packer
// Packs the decrypted byte stream into 32-bit words, buffers them in a small
// FIFO and presents them on a valid/ready port. The decrypt pipe cannot be
// stalled, so a word arriving at a full FIFO (without a coincident pop) is
// dropped and recorded in a sticky overflow flag.
//
// Optional feature macro: DECRYPT_PACK_BYTE_CNT_EN
//   defined     -> byte_cnt counts every accepted byte (v=1), wrapping at 16 bits
//   not defined -> byte_cnt is tied to zero, port list unchanged
module decrypt_word_packer #(
    parameter int DEPTH      = 4,     // FIFO entries, power of two, >= 2
    parameter bit BIG_ENDIAN = 1'b0   // 1: first byte lands in bits 31:24
) (
    input  logic                   clk,
    input  logic                   rst,
    decrypt_word_packer_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    // Pack state is the number of bytes already held in the pack register.
    typedef enum logic [1:0] {
        PK_EMPTY = 2'd0,
        PK_ONE   = 2'd1,
        PK_TWO   = 2'd2,
        PK_THREE = 2'd3
    } pack_state_e;

    pack_state_e    pack_cnt_q, pack_cnt_d;
    logic [31:0]    pack_q, pack_d;
    logic [31:0]    merged_word;
    logic [2:0]     eff_cnt;
    logic           push;
    logic [2:0]     push_bytes;

    // Word storage: small register file, head is read directly so a word
    // pushed on one edge is visible on the very next cycle.
    logic [31:0]    mem_data  [DEPTH];
    logic [2:0]     mem_bytes [DEPTH];

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]  fill_q, fill_d;
    logic           out_valid_q;
    logic           overflow_q, overflow_d;
    logic           pop;
    logic           fifo_full;
    logic           accept;
    logic           drop;

    // ------------------------------------------------------------------
    // Lane merge: the incoming byte replaces the lane selected by the pack
    // count; lane k maps to bits 8k+7:8k (little) or 31-8k:24-8k (big).
    // Lanes not yet written are still zero because the pack register is
    // cleared whenever a word leaves it.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam int PL = BIG_ENDIAN ? (3 - gi) : gi;
            assign merged_word[8*PL +: 8] =
                (bus.v && (pack_cnt_q == 2'(gi))) ? bus.din : pack_q[8*PL +: 8];
        end
    endgenerate

    // Bytes that would be in the word if it left on this edge.
    assign eff_cnt    = {1'b0, pack_cnt_q} + {2'b00, bus.v};
    assign push_bytes = eff_cnt;

    // Pack FSM next state: a fourth byte or a flush with pending bytes
    // sends the word; a flush alone plus a fourth byte pushes only once.
    always_comb begin
        push       = 1'b0;
        pack_cnt_d = pack_cnt_q;
        pack_d     = pack_q;

        if (eff_cnt == 3'd4) begin
            push = 1'b1;
        end else if (bus.flush && (eff_cnt != 3'd0)) begin
            push = 1'b1;
        end

        if (push) begin
            pack_cnt_d = PK_EMPTY;
            pack_d     = '0;
        end else if (bus.v) begin
            pack_cnt_d = pack_state_e'(pack_cnt_q + 2'd1);
            pack_d     = merged_word;
        end
    end

    // FIFO control: a push is accepted when there is room or when the head
    // leaves on the same edge; otherwise it is dropped and flagged.
    always_comb begin
        pop        = out_valid_q && bus.out_ready;
        fifo_full  = (fill_q == FW'(DEPTH));
        accept     = push && (!fifo_full || pop);
        drop       = push && fifo_full && !pop;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({accept, pop})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase

        // A new drop takes priority over a clear in the same cycle.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // Pack and FIFO control registers; reset discards everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_cnt_q  <= PK_EMPTY;
            pack_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            pack_cnt_q  <= pack_cnt_d;
            pack_q      <= pack_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            out_valid_q <= (fill_d != '0);
            overflow_q  <= overflow_d;
        end
    end

    // Word storage write; contents need no reset since the head is masked
    // whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_data[wr_ptr_q]  <= merged_word;
            mem_bytes[wr_ptr_q] <= push_bytes;
        end
    end

`ifdef DECRYPT_PACK_BYTE_CNT_EN
    logic [15:0] byte_cnt_q;

    // Running count of every byte seen from the decrypt pipe, dropped or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= '0;
        end else if (bus.v) begin
            byte_cnt_q <= byte_cnt_q + 16'd1;
        end
    end

    assign bus.byte_cnt = byte_cnt_q;
`else
    assign bus.byte_cnt = '0;
`endif

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_valid_q ? mem_data[rd_ptr_q]  : '0;
    assign bus.out_bytes  = out_valid_q ? mem_bytes[rd_ptr_q] : '0;
    assign bus.overflow   = overflow_q;
    assign bus.fill_level = fill_q;

endmodule

// File: tb/tb_decrypt_word_packer.sv
// tb_decrypt_word_packer
// Directed vectors against a little-endian and a big-endian packer driven by
// the same stimulus. byte_cnt expectations follow DECRYPT_PACK_BYTE_CNT_EN.
module tb_decrypt_word_packer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       v_r, flush_r, ready_r, clr_r;
    logic [7:0] din_r;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_bytes = 16'd0;

    always #5 clk = ~clk;

    decrypt_word_packer_if #(.DEPTH(DEPTH)) bus_le ();
    decrypt_word_packer_if #(.DEPTH(DEPTH)) bus_be ();

    assign bus_le.v         = v_r;
    assign bus_le.din       = din_r;
    assign bus_le.flush     = flush_r;
    assign bus_le.out_ready = ready_r;
    assign bus_le.clr_ovf   = clr_r;
    assign bus_be.v         = v_r;
    assign bus_be.din       = din_r;
    assign bus_be.flush     = flush_r;
    assign bus_be.out_ready = ready_r;
    assign bus_be.clr_ovf   = clr_r;

    decrypt_word_packer #(.DEPTH(DEPTH), .BIG_ENDIAN(1'b0)) dut_le (
        .clk (clk),
        .rst (rst),
        .bus (bus_le)
    );

    decrypt_word_packer #(.DEPTH(DEPTH), .BIG_ENDIAN(1'b1)) dut_be (
        .clk (clk),
        .rst (rst),
        .bus (bus_be)
    );

    // Single comparison point: one line per checked vector.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    // Advance one clock; land 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        v_r   = 1'b1;
        din_r = b;
        exp_bytes = exp_bytes + 16'd1;
        cycle();
        v_r   = 1'b0;
        din_r = 8'h00;
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef DECRYPT_PACK_BYTE_CNT_EN
        return {16'h0, exp_bytes};
`else
        return 32'h0;
`endif
    endfunction

    logic [31:0] batch_a [4];
    logic [31:0] batch_b [4];

    initial begin
        batch_a = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
        batch_b = '{32'h47464544, 32'h4B4A4948, 32'h4F4E4D4C, 32'h63626160};

        rst = 1'b1; v_r = 1'b0; din_r = 8'h00; flush_r = 1'b0;
        ready_r = 1'b0; clr_r = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst out_valid", 32'(bus_le.out_valid), 32'h0);
        chk("rst out_data", bus_le.out_data, 32'h0);
        chk("rst out_bytes", 32'(bus_le.out_bytes), 32'h0);
        chk("rst fill", 32'(bus_le.fill_level), 32'h0);
        chk("rst overflow", 32'(bus_le.overflow), 32'h0);
        chk("rst byte_cnt", 32'(bus_le.byte_cnt), exp_cnt());

        // Full word, both byte orders
        ready_r = 1'b1;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        chk("word valid", 32'(bus_le.out_valid), 32'h1);
        chk("word le data", bus_le.out_data, 32'h44332211);
        chk("word be data", bus_be.out_data, 32'h11223344);
        chk("word bytes", 32'(bus_le.out_bytes), 32'h4);
        cycle();
        chk("word popped", 32'(bus_le.out_valid), 32'h0);

        // Partial word via flush, then an empty flush
        send_byte(8'hAA); send_byte(8'hBB);
        flush_r = 1'b1; cycle(); flush_r = 1'b0;
        chk("flush data", bus_le.out_data, 32'h0000BBAA);
        chk("flush be data", bus_be.out_data, 32'hAABB0000);
        chk("flush bytes", 32'(bus_le.out_bytes), 32'h2);
        cycle();
        chk("flush popped fill", 32'(bus_le.fill_level), 32'h0);
        flush_r = 1'b1; cycle(); flush_r = 1'b0;
        chk("empty flush fill", 32'(bus_le.fill_level), 32'h0);

        // Fourth byte with flush in the same cycle: exactly one push
        ready_r = 1'b0;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        flush_r = 1'b1; send_byte(8'hDD); flush_r = 1'b0;
        chk("v+flush fill", 32'(bus_le.fill_level), 32'h1);
        chk("v+flush bytes", 32'(bus_le.out_bytes), 32'h4);
        chk("v+flush data", bus_le.out_data, 32'hDD030201);
        cycle();
        chk("v+flush no extra", 32'(bus_le.fill_level), 32'h1);
        ready_r = 1'b1; cycle(); ready_r = 1'b0;
        chk("v+flush drained", 32'(bus_le.fill_level), 32'h0);

        // Overflow: 20 bytes into a 4-deep FIFO with no drain
        for (int i = 0; i < 20; i++) send_byte(8'(8'h10 + i));
        chk("ovf fill", 32'(bus_le.fill_level), 32'h4);
        chk("ovf set", 32'(bus_le.overflow), 32'h1);
        chk("ovf byte_cnt", 32'(bus_le.byte_cnt), exp_cnt());
        ready_r = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain a%0d", k), bus_le.out_data, batch_a[k]);
            cycle();
        end
        ready_r = 1'b0;
        chk("drain a fill", 32'(bus_le.fill_level), 32'h0);
        chk("ovf sticky", 32'(bus_le.overflow), 32'h1);
        clr_r = 1'b1; cycle(); clr_r = 1'b0;
        chk("ovf cleared", 32'(bus_le.overflow), 32'h0);

        // Clear coincident with a new drop: set wins
        for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i));
        send_byte(8'h50); send_byte(8'h51); send_byte(8'h52);
        clr_r = 1'b1; send_byte(8'h53); clr_r = 1'b0;
        chk("clr+drop ovf", 32'(bus_le.overflow), 32'h1);
        chk("clr+drop fill", 32'(bus_le.fill_level), 32'h4);

        // Full FIFO, push coincident with pop is accepted
        clr_r = 1'b1; cycle(); clr_r = 1'b0;
        send_byte(8'h60); send_byte(8'h61); send_byte(8'h62);
        ready_r = 1'b1;
        send_byte(8'h63);
        chk("full push+pop fill", 32'(bus_le.fill_level), 32'h4);
        chk("full push+pop ovf", 32'(bus_le.overflow), 32'h0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain b%0d", k), bus_le.out_data, batch_b[k]);
            cycle();
        end
        ready_r = 1'b0;
        chk("drain b fill", 32'(bus_le.fill_level), 32'h0);

        // Asynchronous reset mid-word with three words queued
        for (int i = 0; i < 12; i++) send_byte(8'(8'h70 + i));
        send_byte(8'h80); send_byte(8'h81);
        chk("pre-rst fill", 32'(bus_le.fill_level), 32'h3);
        #2 rst = 1'b1;
        exp_bytes = 16'd0;
        #1;
        chk("async rst out_valid", 32'(bus_le.out_valid), 32'h0);
        chk("async rst out_data", bus_le.out_data, 32'h0);
        chk("async rst out_bytes", 32'(bus_le.out_bytes), 32'h0);
        chk("async rst fill", 32'(bus_le.fill_level), 32'h0);
        chk("async rst byte_cnt", 32'(bus_le.byte_cnt), 32'h0);
        #1 rst = 1'b0;
        send_byte(8'h90); send_byte(8'h91); send_byte(8'h92); send_byte(8'h93);
        chk("post-rst data", bus_le.out_data, 32'h93929190);
        chk("post-rst be data", bus_be.out_data, 32'h90919293);
        chk("post-rst bytes", 32'(bus_le.out_bytes), 32'h4);
        chk("post-rst fill", 32'(bus_le.fill_level), 32'h1);
        chk("post-rst byte_cnt", 32'(bus_le.byte_cnt), exp_cnt());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
